taus_stream_checker: RTL

Sink-side checker for the combined three-component Tausworthe random stream produced by the generator block. It runs its own copy of the generator from the same seeds and compares every accepted input word against the expected value. It also counts words and mismatches, records the index of the first mismatch, and drives pass/fail status to the board LEDs. It sits at the far end of the random-word link, in hardware loopback or behind a transport under test.

---
 rtl/taus_pkg.sv | 39 +++
 rtl/taus_step.sv | 19 +
 rtl/taus_stream_checker.sv | 133 +++++++++++++
 3 files changed

// File: rtl/taus_pkg.sv
// Shared constants, seed derivation and FSM encodings for the three-component
// Tausworthe generator and its stream checker.
package taus_pkg;

  localparam int          Q0  = 13;
  localparam int          SR0 = 19;
  localparam logic [31:0] M0  = 32'hFFFF_FFFE;
  localparam int          SL0 = 12;
  localparam int          K0  = 31;

  localparam int          Q1  = 2;
  localparam int          SR1 = 25;
  localparam logic [31:0] M1  = 32'hFFFF_FFF8;
  localparam int          SL1 = 4;
  localparam int          K1  = 29;

  localparam int          Q2  = 3;
  localparam int          SR2 = 11;
  localparam logic [31:0] M2  = 32'hFFFF_FFF0;
  localparam int          SL2 = 17;
  localparam int          K2  = 28;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } taus_state_e;

  function automatic logic [31:0] taus_seed(input logic [31:0] d, input int q, input int k);
    return ((d ^ (d << q)) >> k) ^ d;
  endfunction

  function automatic logic [31:0] taus_comp_step(input logic [31:0] s, input int q,
                                                 input int sr, input logic [31:0] m,
                                                 input int sl);
    return (((s << q) ^ s) >> sr) ^ ((s & m) << sl);
  endfunction

endpackage

// File: rtl/taus_step.sv
// One combinational step of the combined Tausworthe generator; shared by the
// generator and the checker so both advance identically.
module taus_step (
  input  logic [31:0] i_s0,
  input  logic [31:0] i_s1,
  input  logic [31:0] i_s2,
  output logic [31:0] o_s0,
  output logic [31:0] o_s1,
  output logic [31:0] o_s2,
  output logic [31:0] o_word
);
  import taus_pkg::*;

  assign o_s0   = taus_comp_step(i_s0, Q0, SR0, M0, SL0);
  assign o_s1   = taus_comp_step(i_s1, Q1, SR1, M1, SL1);
  assign o_s2   = taus_comp_step(i_s2, Q2, SR2, M2, SL2);
  assign o_word = o_s0 ^ o_s1 ^ o_s2;

endmodule

// File: rtl/taus_stream_checker.sv
// Sink-side checker: regenerates the Tausworthe stream locally, compares each
// accepted word, counts words/mismatches and reports pass/fail on the LEDs.
module taus_stream_checker #(
  parameter int          DELAY     = 1,
  parameter logic [31:0] D0        = 32'hDEAD_BEE0,
  parameter logic [31:0] D1        = 32'hCAFE_BAB0,
  parameter logic [31:0] D2        = 32'hACDC_0000,
  parameter int unsigned NUM_WORDS = 1024,
  parameter int unsigned ERR_LIMIT = 0
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        START,
  input  logic        IN_VALID,
  input  logic [31:0] IN_DATA,
  output logic        IN_READY,
  output logic [1:0]  STATE,
  output logic [31:0] WORD_CNT,
  output logic [15:0] ERR_CNT,
  output logic [31:0] FIRST_ERR_IDX,
  output logic        FAIL,
  output logic        DONE,
  output logic [7:0]  GPIO_LED
);
  import taus_pkg::*;

  localparam logic [31:0] SEED0    = taus_seed(D0, Q0, K0);
  localparam logic [31:0] SEED1    = taus_seed(D1, Q1, K1);
  localparam logic [31:0] SEED2    = taus_seed(D2, Q2, K2);
  localparam logic [31:0] LAST_IDX = 32'(NUM_WORDS - 1);
  localparam bit          FREE_RUN = (NUM_WORDS == 0);

  // DELAY keeps the parameter list aligned with the generator; the logic is zero-delay.
  if (DELAY < 0) begin : g_delay_guard
  end

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  taus_state_e r_state;
  logic [31:0] r_s0, r_s1, r_s2, r_exp;
  logic [31:0] r_acc_cnt;
  logic        r_vld_p0, r_mis_p0;
  logic [31:0] r_word_cnt_p1, r_first_idx_p1;
  logic [15:0] r_err_cnt_p1;
  logic        r_done_p1, r_done_p2, r_fail_p2;

  logic        w_load, w_accept, w_mis;
  logic [31:0] w_in0, w_in1, w_in2;
  logic [31:0] w_nx0, w_nx1, w_nx2, w_word;

  assign w_load   = RESET || START;
  assign w_accept = (r_state == ST_RUN) && IN_VALID && !START;
  assign w_mis    = |(IN_DATA ^ r_exp);

  // Loading steps the seeds once, so r_exp always holds the next expected word.
  assign w_in0 = w_load ? SEED0 : r_s0;
  assign w_in1 = w_load ? SEED1 : r_s1;
  assign w_in2 = w_load ? SEED2 : r_s2;

  taus_step u_step (
    .i_s0  (w_in0),
    .i_s1  (w_in1),
    .i_s2  (w_in2),
    .o_s0  (w_nx0),
    .o_s1  (w_nx1),
    .o_s2  (w_nx2),
    .o_word(w_word)
  );

  always_ff @(posedge CLK) begin
    if (w_load || w_accept) begin
      r_s0  <= w_nx0;
      r_s1  <= w_nx1;
      r_s2  <= w_nx2;
      r_exp <= w_word;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET || START) begin
      r_state        <= RESET ? ST_IDLE : ST_RUN;
      r_acc_cnt      <= 32'd0;
      r_vld_p0       <= 1'b0;
      r_mis_p0       <= 1'b0;
      r_word_cnt_p1  <= 32'd0;
      r_err_cnt_p1   <= 16'd0;
      r_first_idx_p1 <= 32'hFFFF_FFFF;
      r_done_p1      <= 1'b0;
      r_done_p2      <= 1'b0;
      r_fail_p2      <= 1'b0;
    end else begin
      // stage p0: accept, compare against registered expected word, FSM
      r_vld_p0 <= w_accept;
      r_mis_p0 <= w_accept && w_mis;
      case (r_state)
        ST_RUN: begin
          if (w_accept) begin
            r_acc_cnt <= r_acc_cnt + 32'd1;
            if (!FREE_RUN && (r_acc_cnt == LAST_IDX)) r_state <= ST_DONE;
          end
        end
        ST_IDLE, ST_DONE: ;
        default: r_state <= ST_IDLE;
      endcase

      // stage p1: word/error counters
      if (r_vld_p0) begin
        r_word_cnt_p1 <= r_word_cnt_p1 + 32'd1;
        if (r_mis_p0) begin
          r_err_cnt_p1 <= sat_inc16(r_err_cnt_p1);
          if (r_err_cnt_p1 == 16'd0) r_first_idx_p1 <= r_word_cnt_p1;
        end
      end
      r_done_p1 <= (r_state == ST_DONE);

      // stage p2: status flags
      r_done_p2 <= r_done_p1;
      r_fail_p2 <= r_fail_p2 || ({16'd0, r_err_cnt_p1} > 32'(ERR_LIMIT));
    end
  end

  assign IN_READY      = (r_state == ST_RUN);
  assign STATE         = r_state;
  assign WORD_CNT      = r_word_cnt_p1;
  assign ERR_CNT       = r_err_cnt_p1;
  assign FIRST_ERR_IDX = r_first_idx_p1;
  assign FAIL          = r_fail_p2;
  assign DONE          = r_done_p2;
  assign GPIO_LED      = {r_state, r_fail_p2, r_done_p2, r_err_cnt_p1[3:0]};

endmodule
